calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
Top-level entry sequencer for the four-function calculator. It turns one-cycle button pulses from the input manager into the FSM flags (ld_a, ld_op, ld_b) used by the operand, sign and display blocks. It issues start to the ALU and waits for done, or for a timeout. It also drives the memory store/recall flag bus and one-shot clear/chain strobes.

Parameters:
TIMEOUT, 255, max cycles in S_WAIT without alu_done before error
TW, 8, width of wait counter; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  500 Hz system clock
reset  in  1  synchronous, active-high reset
pulse  in  5  one-cycle key pulses: [0] next, [1] equals, [2] clear, [3] memory, [4] negate (not consumed here)
op_sel  in  2  operation switches: 0 add, 1 sub, 2 mul, 3 div
alu_done  in  1  ALU result ready, one-cycle pulse
alu_err  in  1  ALU error (div-by-zero/overflow), valid with alu_done
ld_a  out  1  entering operand A
ld_op  out  1  selecting operation
ld_b  out  1  entering operand B
op_code  out  2  latched operation
alu_start  out  1  one-cycle ALU start
clear  out  1  one-cycle clear of the currently loaded operand
clear_all  out  1  one-cycle clear of A, B, signs and display
chain_a  out  1  one-cycle: copy result into operand A
mem_flag  out  5  5'b10010 recall, 5'b10001 store, 5'b00000 idle; one cycle
result_valid  out  1  result on display
err  out  1  error state
err_code  out  2  0 none, 1 ALU error, 2 timeout

Behaviour:
- States: S_A, S_OP, S_B, S_EXEC, S_WAIT, S_RESULT, S_ERR.
- Flags are Moore-decoded from the state register: ld_a = S_A, ld_op = S_OP, ld_b = S_B, result_valid = S_RESULT, err = S_ERR.
- One-shots (clear, clear_all, chain_a, alu_start, mem_flag) are registered and last exactly one cycle.
- Latency: a pulse sampled at edge n gives the new state and one-shots during cycle n+1.
- Pulse priority within one cycle: clear > memory > equals > next. Lower-priority pulses in the same cycle are dropped.
- Reset (any state, including mid-S_WAIT):
  - state goes to S_A;
  - op_code, err_code, counter and all one-shots go to 0;
  - mem_flag goes to 0.
- S_A:
  - pulse[2]: clear=1, stay. ld_a stays high, so only A clears.
  - pulse[3]: mem_flag=10010, stay.
  - pulse[0]: go to S_OP.
  - pulse[1]: ignored.
- S_OP:
  - pulse[0]: op_code<=op_sel, go to S_B.
  - pulse[2]: clear_all, go to S_A.
  - pulse[3], pulse[1]: ignored.
- S_B:
  - pulse[2]: clear=1, stay.
  - pulse[3]: mem_flag=10010, stay.
  - pulse[0] or pulse[1]: go to S_EXEC.
- S_EXEC: alu_start=1 for one cycle, counter<=0, go to S_WAIT unconditionally.
- S_WAIT:
  - counter increments each cycle.
  - alu_done with alu_err=0: go to S_RESULT.
  - alu_done with alu_err=1: go to S_ERR, err_code=1.
  - counter==TIMEOUT-1 without alu_done: go to S_ERR, err_code=2.
  - alu_done on the timeout cycle wins over the timeout.
  - pulse[2]: abort, clear_all, go to S_A.
  - Other pulses: ignored.
- S_RESULT:
  - pulse[3]: mem_flag=10001, stay.
  - pulse[0]: chain_a=1, go to S_OP.
  - pulse[1]: chain_a=1, go to S_EXEC (repeat the last op with the same B, op_code unchanged).
  - pulse[2]: clear_all, go to S_A.
- S_ERR: only pulse[2] leaves it (clear_all, err_code<=0, go to S_A). All other pulses are ignored.
- alu_done outside S_WAIT is ignored.
- op_sel is sampled only on the S_OP→S_B transition.

Decomposition:
- Package calc_pkg holds:
  - state enum;
  - pulse bit indices (P_NEXT=0, P_EQ=1, P_CLR=2, P_MEM=3, P_NEG=4);
  - MEM_RECALL=5'b10010, MEM_STORE=5'b10001, MEM_IDLE=5'b00000;
  - op codes;
  - err codes.
- One sub-module, calc_wait_timer: clear/enable counter with a terminal-count output at TIMEOUT-1.

Test Plan:
- Reset, then pulse[0] at cycle 2, op_sel=2, pulse[0], pulse[1] → ld_a, ld_op, ld_b each high in turn; op_code=2; alu_start high exactly one cycle; state S_WAIT.
- In S_WAIT, alu_done=1 with alu_err=0 after 5 cycles → result_valid=1 next cycle. Then pulse[3] → mem_flag=10001 for one cycle. Then pulse[0] → chain_a=1 and ld_op=1 in the same cycle.
- In S_WAIT with no alu_done, TIMEOUT=8 → err=1 and err_code=2 after 8 wait cycles. pulse[0] ignored. pulse[2] → clear_all=1, then ld_a=1 and err_code=0.
- In S_B, pulse=5'b01100 (clear+mem) → clear=1, mem_flag=0, ld_b still 1. Next pulse[3] → mem_flag=10010 with ld_b=1.
- alu_done with alu_err=1 (div by zero, op_code=3) → err_code=1. Then pulse[1] in S_RESULT after recovery → chain_a=1 and alu_start one cycle later, op_code unchanged.
- reset asserted mid-S_WAIT at count 3 → next cycle ld_a=1, all one-shots 0, a later alu_done is ignored.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator entry sequencer.
package calc_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_A      = 3'd0,
    S_OP     = 3'd1,
    S_B      = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_RESULT = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Bit positions within the key pulse bus.
  localparam int P_NEXT = 0;
  localparam int P_EQ   = 1;
  localparam int P_CLR  = 2;
  localparam int P_MEM  = 3;
  localparam int P_NEG  = 4;

  // Memory flag bus encodings.
  localparam logic [4:0] MEM_RECALL = 5'b10010;
  localparam logic [4:0] MEM_STORE  = 5'b10001;
  localparam logic [4:0] MEM_IDLE   = 5'b00000;

  // Operation codes.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Error codes.
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALU     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/calc_seq_ctrl_wait_timer.sv
// Wait counter for the ALU handshake: cleared on start, counts while
// enabled, flags the terminal count TIMEOUT-1.
module calc_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Clear takes priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator entry sequencer: turns key pulses into load flags, runs the
// ALU start/done handshake with a timeout, and emits one-cycle strobes.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] pulse,
  input  logic [1:0] op_sel,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       ld_a,
  output logic       ld_op,
  output logic       ld_b,
  output logic [1:0] op_code,
  output logic       alu_start,
  output logic       clear,
  output logic       clear_all,
  output logic       chain_a,
  output logic [4:0] mem_flag,
  output logic       result_valid,
  output logic       err,
  output logic [1:0] err_code
);

  state_t     state_q, state_d;
  logic [1:0] op_code_q, op_code_d;
  logic [1:0] err_code_q, err_code_d;
  logic       alu_start_q, alu_start_d;
  logic       clear_q, clear_d;
  logic       clear_all_q, clear_all_d;
  logic       chain_a_q, chain_a_d;
  logic [4:0] mem_flag_q, mem_flag_d;
  logic       timer_tc;
  logic       unused_neg;

  logic p_next, p_eq, p_clr, p_mem;
  assign p_next     = pulse[P_NEXT];
  assign p_eq       = pulse[P_EQ];
  assign p_clr      = pulse[P_CLR];
  assign p_mem      = pulse[P_MEM];
  // Negate is handled by the sign block, not here.
  assign unused_neg = pulse[P_NEG];

  calc_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == S_EXEC),
    .en_i  (state_q == S_WAIT),
    .tc_o  (timer_tc)
  );

  // Next-state and one-shot decode; priority clear > memory > equals > next.
  always_comb begin
    state_d     = state_q;
    op_code_d   = op_code_q;
    err_code_d  = err_code_q;
    alu_start_d = 1'b0;
    clear_d     = 1'b0;
    clear_all_d = 1'b0;
    chain_a_d   = 1'b0;
    mem_flag_d  = MEM_IDLE;
    case (state_q)
      S_A: begin
        if (p_clr) begin
          clear_d = 1'b1;
        end else if (p_mem) begin
          mem_flag_d = MEM_RECALL;
        end else if (p_next) begin
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (p_clr) begin
          clear_all_d = 1'b1;
          state_d     = S_A;
        end else if (p_next) begin
          op_code_d = op_sel;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (p_clr) begin
          clear_d = 1'b1;
        end else if (p_mem) begin
          mem_flag_d = MEM_RECALL;
        end else if (p_eq || p_next) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_start_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (p_clr) begin
          clear_all_d = 1'b1;
          state_d     = S_A;
        end else if (alu_done) begin
          if (alu_err) begin
            err_code_d = ERR_ALU;
            state_d    = S_ERR;
          end else begin
            state_d = S_RESULT;
          end
        end else if (timer_tc) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end
      end
      S_RESULT: begin
        if (p_clr) begin
          clear_all_d = 1'b1;
          state_d     = S_A;
        end else if (p_mem) begin
          mem_flag_d = MEM_STORE;
        end else if (p_eq) begin
          chain_a_d = 1'b1;
          state_d   = S_EXEC;
        end else if (p_next) begin
          chain_a_d = 1'b1;
          state_d   = S_OP;
        end
      end
      S_ERR: begin
        if (p_clr) begin
          clear_all_d = 1'b1;
          err_code_d  = ERR_NONE;
          state_d     = S_A;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  // State, latched operation/error and one-shot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_A;
      op_code_q   <= OP_ADD;
      err_code_q  <= ERR_NONE;
      alu_start_q <= 1'b0;
      clear_q     <= 1'b0;
      clear_all_q <= 1'b0;
      chain_a_q   <= 1'b0;
      mem_flag_q  <= MEM_IDLE;
    end else begin
      state_q     <= state_d;
      op_code_q   <= op_code_d;
      err_code_q  <= err_code_d;
      alu_start_q <= alu_start_d;
      clear_q     <= clear_d;
      clear_all_q <= clear_all_d;
      chain_a_q   <= chain_a_d;
      mem_flag_q  <= mem_flag_d;
    end
  end

  assign ld_a         = (state_q == S_A);
  assign ld_op        = (state_q == S_OP);
  assign ld_b         = (state_q == S_B);
  assign result_valid = (state_q == S_RESULT);
  assign err          = (state_q == S_ERR);
  assign op_code      = op_code_q;
  assign err_code     = err_code_q;
  assign alu_start    = alu_start_q;
  assign clear        = clear_q;
  assign clear_all    = clear_all_q;
  assign chain_a      = chain_a_q;
  assign mem_flag     = mem_flag_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with a short timeout.
module tb_calc_seq_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] pulse;
  logic [1:0] op_sel;
  logic       alu_done;
  logic       alu_err;
  logic       ld_a, ld_op, ld_b;
  logic [1:0] op_code;
  logic       alu_start, clear, clear_all, chain_a;
  logic [4:0] mem_flag;
  logic       result_valid, err;
  logic [1:0] err_code;

  int n_chk  = 0;
  int n_fail = 0;

  calc_seq_ctrl #(.TIMEOUT(8), .TW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pulse        (pulse),
    .op_sel       (op_sel),
    .alu_done     (alu_done),
    .alu_err      (alu_err),
    .ld_a         (ld_a),
    .ld_op        (ld_op),
    .ld_b         (ld_b),
    .op_code      (op_code),
    .alu_start    (alu_start),
    .clear        (clear),
    .clear_all    (clear_all),
    .chain_a      (chain_a),
    .mem_flag     (mem_flag),
    .result_valid (result_valid),
    .err          (err),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, take one edge, then release pulses.
  task automatic step(input logic [4:0] p, input logic d, input logic e);
    pulse    = p;
    alu_done = d;
    alu_err  = e;
    @(posedge clk);
    #1;
    pulse    = 5'b0;
    alu_done = 1'b0;
    alu_err  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(5'b00001, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    n_chk++; if (ld_a !== 1'b1) begin n_fail++; $display("FAIL reset_ld_a got=%0b exp=1", ld_a); end
    n_chk++; if (op_code !== 2'd0) begin n_fail++; $display("FAIL reset_op_code got=%0d exp=0", op_code); end
    n_chk++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
    n_chk++; if ({alu_start, clear, clear_all, chain_a, mem_flag} !== 9'b0) begin n_fail++; $display("FAIL reset_oneshots got=%b exp=0", {alu_start, clear, clear_all, chain_a, mem_flag}); end
    n_chk++; if ({ld_op, ld_b, result_valid, err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {ld_op, ld_b, result_valid, err}); end
    reset = 1'b0;
  endtask

  task automatic test_basic_flow();
    step(5'b00000, 1'b0, 1'b0);
    step(5'b00010, 1'b0, 1'b0);  // equals ignored in S_A
    n_chk++; if (ld_a !== 1'b1) begin n_fail++; $display("FAIL a_eq_ignored ld_a got=%0b exp=1", ld_a); end
    step(5'b00001, 1'b0, 1'b0);
    n_chk++; if ({ld_a, ld_op, ld_b} !== 3'b010) begin n_fail++; $display("FAIL flow_ld_op got=%b exp=010", {ld_a, ld_op, ld_b}); end
    op_sel = 2'd2;
    step(5'b00001, 1'b0, 1'b0);
    op_sel = 2'd0;
    n_chk++; if ({ld_a, ld_op, ld_b} !== 3'b001) begin n_fail++; $display("FAIL flow_ld_b got=%b exp=001", {ld_a, ld_op, ld_b}); end
    n_chk++; if (op_code !== 2'd2) begin n_fail++; $display("FAIL flow_op_code got=%0d exp=2", op_code); end
    step(5'b00010, 1'b0, 1'b0);  // S_EXEC
    n_chk++; if ({ld_b, alu_start} !== 2'b00) begin n_fail++; $display("FAIL flow_exec got=%b exp=00", {ld_b, alu_start}); end
    step(5'b00000, 1'b0, 1'b0);  // S_WAIT, count 0
    n_chk++; if (alu_start !== 1'b1) begin n_fail++; $display("FAIL flow_alu_start got=%0b exp=1", alu_start); end
    step(5'b00000, 1'b0, 1'b0);  // count 1
    n_chk++; if (alu_start !== 1'b0) begin n_fail++; $display("FAIL flow_alu_start_once got=%0b exp=0", alu_start); end
    step(5'b00001, 1'b0, 1'b0);  // next ignored while waiting
    step(5'b00000, 1'b0, 1'b0);
    step(5'b00000, 1'b0, 1'b0);
    n_chk++; if ({result_valid, err, ld_a, ld_op, ld_b} !== 5'b0) begin n_fail++; $display("FAIL flow_waiting got=%b exp=00000", {result_valid, err, ld_a, ld_op, ld_b}); end
    step(5'b00000, 1'b1, 1'b0);
    n_chk++; if ({result_valid, err} !== 2'b10) begin n_fail++; $display("FAIL flow_result got=%b exp=10", {result_valid, err}); end
    step(5'b01000, 1'b0, 1'b0);
    n_chk++; if (mem_flag !== 5'b10001) begin n_fail++; $display("FAIL flow_mem_store got=%b exp=10001", mem_flag); end
    n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL flow_store_stay got=%0b exp=1", result_valid); end
    step(5'b00000, 1'b0, 1'b0);
    n_chk++; if (mem_flag !== 5'b00000) begin n_fail++; $display("FAIL flow_mem_once got=%b exp=00000", mem_flag); end
    step(5'b00001, 1'b0, 1'b0);
    n_chk++; if ({chain_a, ld_op} !== 2'b11) begin n_fail++; $display("FAIL flow_chain_next got=%b exp=11", {chain_a, ld_op}); end
    step(5'b00000, 1'b0, 1'b0);
    n_chk++; if (chain_a !== 1'b0) begin n_fail++; $display("FAIL flow_chain_once got=%0b exp=0", chain_a); end
  endtask

  task automatic test_timeout();
    op_sel = 2'd1;
    step(5'b00001, 1'b0, 1'b0);  // S_B
    step(5'b00001, 1'b0, 1'b0);  // S_EXEC
    step(5'b00000, 1'b0, 1'b0);  // wait cycle 1
    for (int i = 0; i < 7; i++) step(5'b00000, 1'b0, 1'b0);  // wait cycle 8
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_not_yet got=%0b exp=0", err); end
    step(5'b00000, 1'b0, 1'b0);
    n_chk++; if ({err, err_code} !== 3'b110) begin n_fail++; $display("FAIL to_err got=%b exp=110", {err, err_code}); end
    step(5'b00011, 1'b0, 1'b0);
    n_chk++; if ({err, err_code, ld_a} !== 4'b1100) begin n_fail++; $display("FAIL to_ignore got=%b exp=1100", {err, err_code, ld_a}); end
    step(5'b00100, 1'b0, 1'b0);
    n_chk++; if ({clear_all, ld_a, err, err_code} !== 5'b11000) begin n_fail++; $display("FAIL to_recover got=%b exp=11000", {clear_all, ld_a, err, err_code}); end
    step(5'b00000, 1'b0, 1'b0);
    n_chk++; if (clear_all !== 1'b0) begin n_fail++; $display("FAIL to_clear_all_once got=%0b exp=0", clear_all); end
  endtask

  task automatic test_clear_mem_priority();
    step(5'b00001, 1'b0, 1'b0);  // S_OP
    op_sel = 2'd3;
    step(5'b00001, 1'b0, 1'b0);  // S_B, op_code 3
    op_sel = 2'd0;
    n_chk++; if ({ld_b, op_code} !== 3'b111) begin n_fail++; $display("FAIL pri_in_b got=%b exp=111", {ld_b, op_code}); end
    step(5'b01100, 1'b0, 1'b0);
    n_chk++; if ({clear, mem_flag, ld_b} !== 7'b1000001) begin n_fail++; $display("FAIL pri_clear_mem got=%b exp=1000001", {clear, mem_flag, ld_b}); end
    step(5'b01000, 1'b0, 1'b0);
    n_chk++; if ({clear, mem_flag, ld_b} !== 7'b0100101) begin n_fail++; $display("FAIL pri_recall got=%b exp=0100101", {clear, mem_flag, ld_b}); end
    step(5'b00000, 1'b0, 1'b0);
    n_chk++; if (mem_flag !== 5'b00000) begin n_fail++; $display("FAIL pri_recall_once got=%b exp=00000", mem_flag); end
  endtask

  task automatic test_alu_err_chain();
    step(5'b00010, 1'b0, 1'b0);  // S_EXEC
    step(5'b00000, 1'b0, 1'b0);  // wait cycle 1
    step(5'b00000, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b1);
    n_chk++; if ({err, err_code, op_code} !== 5'b10111) begin n_fail++; $display("FAIL aerr_code got=%b exp=10111", {err, err_code, op_code}); end
    step(5'b00100, 1'b0, 1'b0);
    n_chk++; if ({ld_a, err_code} !== 3'b100) begin n_fail++; $display("FAIL aerr_recover got=%b exp=100", {ld_a, err_code}); end
    step(5'b00001, 1'b0, 1'b0);
    op_sel = 2'd3;
    step(5'b00001, 1'b0, 1'b0);  // S_B
    op_sel = 2'd0;
    step(5'b00010, 1'b0, 1'b0);  // S_EXEC
    step(5'b00000, 1'b0, 1'b0);
    step(5'b00000, 1'b1, 1'b0);
    n_chk++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL chain_result got=%0b exp=1", result_valid); end
    step(5'b00010, 1'b0, 1'b0);
    n_chk++; if ({chain_a, alu_start, result_valid} !== 3'b100) begin n_fail++; $display("FAIL chain_eq got=%b exp=100", {chain_a, alu_start, result_valid}); end
    step(5'b00000, 1'b0, 1'b0);
    n_chk++; if ({chain_a, alu_start, op_code} !== 4'b0111) begin n_fail++; $display("FAIL chain_restart got=%b exp=0111", {chain_a, alu_start, op_code}); end
  endtask

  task automatic test_reset_mid_wait();
    step(5'b00000, 1'b0, 1'b0);  // count 1
    step(5'b00000, 1'b0, 1'b0);  // count 2
    step(5'b00000, 1'b0, 1'b0);  // count 3
    reset = 1'b1;
    step(5'b00000, 1'b0, 1'b0);
    reset = 1'b0;
    n_chk++; if (ld_a !== 1'b1) begin n_fail++; $display("FAIL rst_wait_ld_a got=%0b exp=1", ld_a); end
    n_chk++; if ({alu_start, clear, clear_all, chain_a, mem_flag, op_code, err_code} !== 13'b0) begin n_fail++; $display("FAIL rst_wait_regs got=%b exp=0", {alu_start, clear, clear_all, chain_a, mem_flag, op_code, err_code}); end
    step(5'b00000, 1'b1, 1'b0);
    n_chk++; if ({ld_a, result_valid, err} !== 3'b100) begin n_fail++; $display("FAIL rst_wait_done_ignored got=%b exp=100", {ld_a, result_valid, err}); end
  endtask

  initial begin
    reset    = 1'b1;
    pulse    = 5'b0;
    op_sel   = 2'd0;
    alu_done = 1'b0;
    alu_err  = 1'b0;
    test_reset();
    test_basic_flow();
    test_timeout();
    test_clear_mem_priority();
    test_alu_err_chain();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
